// File: rtl/drift_event_readout.sv
// Drift-tube event builder: SCIN_COIN opens a hit window, then the latched
// first-hit times are streamed as header / channel words / trailer to the FIFO.
module drift_event_readout #(
    parameter int N_CH    = 32,
    parameter int WINDOW  = 256,
    parameter int HOLDOFF = 11,
    parameter int ZS      = 0
) (
    input  logic            clk100,
    input  logic            CLR_N,
    input  logic            SCIN_COIN,
    input  logic [N_CH-1:0] TUBE,
    input  logic            FIFO_FULL,
    output logic [15:0]     FIFO_DIN,
    output logic            FIFO_WR_EN,
    output logic            BUSY,
    output logic [7:0]      EVT_NUM,
    output logic [15:0]     MISSED
);

    localparam logic [7:0] WIN_LAST  = 8'(WINDOW - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_HDR, S_DATA, S_TRL, S_HOLD
    } state_t;

    state_t               state_q;
    logic [7:0]           win_q;
    logic [7:0]           hold_q;
    logic [7:0]           evt_q;
    logic [6:0]           ch_q;
    logic [N_CH-1:0]      hit_q;
    logic [N_CH-1:0][7:0] time_q;
    logic                 coin_q;
    logic [15:0]          missed_q;
    logic [15:0]          din_q;
    logic                 wr_en_q;
    logic                 busy_q;

    logic [N_CH-1:0]      sel;
    logic [7:0]           start;
    logic [6:0]           ch_d;
    logic                 ch_vld_d;
    logic [15:0]          word_d;

    // Next channel to emit: lowest selected index at or above start.
    // With zero-suppression only hit channels are selected.
    always_comb begin
        sel      = (ZS != 0) ? hit_q : '1;
        start    = (state_q == S_DATA) ? ({1'b0, ch_q} + 8'd1) : 8'd0;
        ch_d     = '0;
        ch_vld_d = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (sel[i] && (8'(i) >= start)) begin
                ch_vld_d = 1'b1;
                ch_d     = 7'(i);
            end
        end
        word_d = 16'hFFFF;
        for (int i = 0; i < N_CH; i++) begin
            if (7'(i) == ch_q) begin
                word_d = {time_q[i], hit_q[i], 7'(i)};
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (!CLR_N) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            hold_q   <= '0;
            evt_q    <= '0;
            ch_q     <= '0;
            hit_q    <= '0;
            time_q   <= '0;
            coin_q   <= 1'b0;
            missed_q <= '0;
            din_q    <= 16'hFFFF;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            coin_q  <= SCIN_COIN;
            wr_en_q <= 1'b0;
            din_q   <= 16'hFFFF;
            if (SCIN_COIN && !coin_q && busy_q &&
                (missed_q != 16'hFFFF)) begin
                missed_q <= missed_q + 16'd1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (SCIN_COIN) begin
                        state_q <= S_ARM;
                        busy_q  <= 1'b1;
                        evt_q   <= evt_q + 8'd1;
                        win_q   <= '0;
                        hit_q   <= '0;
                        time_q  <= '0;
                    end
                end
                S_ARM: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (TUBE[i] && !hit_q[i]) begin
                            hit_q[i]  <= 1'b1;
                            time_q[i] <= win_q;
                        end
                    end
                    win_q <= win_q + 8'd1;
                    if (win_q == WIN_LAST) begin
                        state_q <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (!FIFO_FULL) begin
                        wr_en_q <= 1'b1;
                        din_q   <= {8'hA5, evt_q};
                        if (ch_vld_d) begin
                            ch_q    <= ch_d;
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_TRL;
                        end
                    end
                end
                S_DATA: begin
                    if (!FIFO_FULL) begin
                        wr_en_q <= 1'b1;
                        din_q   <= word_d;
                        if (ch_vld_d) begin
                            ch_q <= ch_d;
                        end else begin
                            state_q <= S_TRL;
                        end
                    end
                end
                S_TRL: begin
                    if (!FIFO_FULL) begin
                        wr_en_q <= 1'b1;
                        din_q   <= 16'hFFFF;
                        hold_q  <= '0;
                        if (HOLDOFF == 0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    hold_q <= hold_q + 8'd1;
                    if (hold_q == HOLD_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign FIFO_DIN   = din_q;
    assign FIFO_WR_EN = wr_en_q;
    assign BUSY       = busy_q;
    assign EVT_NUM    = evt_q;
    assign MISSED     = missed_q;

endmodule
